condicionador_de_entradas: RTL and testbench

CONDICIONADOR_DE_ENTRADAS -- requirements
Module: condicionador_de_entradas

---
 rtl/condicionador_de_entradas.sv | 100 ++++++++++
 tb/tb_condicionador_de_entradas.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_de_entradas.sv
// Input conditioner: synchronizes and debounces eight switches and four active-low
// buttons, exposes them as two 6-bit groups and pulses one event flag per group on change.
module condicionador_de_entradas #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CH0,
    input  logic       CH1,
    input  logic       CH2,
    input  logic       CH3,
    input  logic       CH4,
    input  logic       CH5,
    input  logic       CH6,
    input  logic       CH7,
    input  logic       BTN0,
    input  logic       BTN1,
    input  logic       BTN2,
    input  logic       BTN3,
    output logic [2:0] User0,
    output logic [2:0] Func0,
    output logic [2:0] User1,
    output logic [2:0] Func1,
    output logic       Evento0,
    output logic       Evento1
);

    localparam int NUM_IN = 12;
    // Bit order: [7:0] = CH7..CH0, [11:8] = BTN3..BTN0; buttons idle high.
    localparam logic [NUM_IN-1:0] REST_LEVEL  = 12'hF00;
    localparam logic [NUM_IN-1:0] GROUP0_MASK = 12'h30F;
    localparam logic [15:0]       LAST_COUNT  = 16'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] sync_p0;
    logic [NUM_IN-1:0] sync_p1;
    logic [NUM_IN-1:0] stable;
    logic [NUM_IN-1:0] differ;
    logic [NUM_IN-1:0] accept;
    logic [15:0]       cnt [NUM_IN];
    logic              evt0;
    logic              evt1;

    function automatic logic [15:0] next_count(input logic diff, input logic at_last,
                                               input logic [15:0] count);
        if (!diff || at_last) begin
            return 16'd0;
        end
        return count + 16'd1;
    endfunction

    assign raw = {BTN3, BTN2, BTN1, BTN0, CH7, CH6, CH5, CH4, CH3, CH2, CH1, CH0};

    // Stage p0/p1: two-flop synchronizer on every raw input
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_p0 <= REST_LEVEL;
            sync_p1 <= REST_LEVEL;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    assign differ = sync_p1 ^ stable;

    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            accept[i] = differ[i] && (cnt[i] == LAST_COUNT);
        end
    end

    // Debounce stage: a level is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stable <= REST_LEVEL;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= 16'd0;
            end
            evt0 <= 1'b0;
            evt1 <= 1'b0;
        end else begin
            stable <= stable ^ accept;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= next_count(differ[i], accept[i], cnt[i]);
            end
            evt0 <= |(accept & GROUP0_MASK);
            evt1 <= |(accept & ~GROUP0_MASK);
        end
    end

    assign User0   = {stable[0], stable[1], stable[2]};
    assign Func0   = {stable[3], ~stable[8], ~stable[9]};
    assign User1   = {stable[4], stable[5], stable[6]};
    assign Func1   = {stable[7], ~stable[10], ~stable[11]};
    assign Evento0 = evt0;
    assign Evento1 = evt1;

endmodule

// File: tb/tb_condicionador_de_entradas.sv
// Bench for condicionador_de_entradas: directed scenarios plus random input activity,
// every cycle compared against a run-length debounce model.
module tb_condicionador_de_entradas;

    localparam int N = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] ch    = 8'h00;
    logic [3:0] btn   = 4'hF;
    logic [2:0] User0, Func0, User1, Func1;
    logic       Evento0, Evento1;

    int total = 0;
    int bad   = 0;

    // Model state: raw samples seen by the last two edges, accepted level, differing run length.
    logic [11:0] m_d1, m_d2, m_stab;
    int          m_run [12];
    logic        m_ev0, m_ev1;

    condicionador_de_entradas #(.DEBOUNCE_CYCLES(N)) dut (
        .Clock(Clock), .Reset(Reset),
        .CH0(ch[0]), .CH1(ch[1]), .CH2(ch[2]), .CH3(ch[3]),
        .CH4(ch[4]), .CH5(ch[5]), .CH6(ch[6]), .CH7(ch[7]),
        .BTN0(btn[0]), .BTN1(btn[1]), .BTN2(btn[2]), .BTN3(btn[3]),
        .User0(User0), .Func0(Func0), .User1(User1), .Func1(Func1),
        .Evento0(Evento0), .Evento1(Evento1)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_group0(input int i);
        return (i <= 3) || (i == 8) || (i == 9);
    endfunction

    task automatic model_reset();
        m_d1   = 12'hF00;
        m_d2   = 12'hF00;
        m_stab = 12'hF00;
        m_ev0  = 1'b0;
        m_ev1  = 1'b0;
        for (int i = 0; i < 12; i++) m_run[i] = 0;
    endtask

    function automatic logic [13:0] model_out();
        return {m_stab[0], m_stab[1], m_stab[2], m_stab[3], ~m_stab[8], ~m_stab[9],
                m_stab[4], m_stab[5], m_stab[6], m_stab[7], ~m_stab[10], ~m_stab[11],
                m_ev0, m_ev1};
    endfunction

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic tick(input string tag);
        logic [11:0] raw;
        @(posedge Clock);
        raw = {btn, ch};
        if (Reset) begin
            model_reset();
        end else begin
            m_ev0 = 1'b0;
            m_ev1 = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (m_d2[i] != m_stab[i]) begin
                    m_run[i]++;
                    if (m_run[i] == N) begin
                        m_stab[i] = m_d2[i];
                        m_run[i]  = 0;
                        if (in_group0(i)) m_ev0 = 1'b1;
                        else              m_ev1 = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = raw;
        end
        #1;
        check(tag, {2'b00, User0, Func0, User1, Func1, Evento0, Evento1}, {2'b00, model_out()});
    endtask

    task automatic ticks(input int n, input string tag);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    int pulses;

    initial begin
        model_reset();

        // Reset state
        ticks(2, "reset");
        check("reset_outs", {4'h0, User0, Func0, User1, Func1}, 16'h0000);
        check("reset_evt", {14'h0, Evento0, Evento1}, 16'h0000);
        Reset = 1'b0;
        ticks(3, "post_reset");
        check("release_no_evt", {14'h0, Evento0, Evento1}, 16'h0000);

        // CH0 held: accepted on the 6th edge, one Evento0
        ch[0] = 1'b1;
        ticks(5, "ch0_wait");
        check("ch0_not_yet", {13'h0, User0}, 16'h0000);
        tick("ch0_edge");
        check("ch0_user0", {13'h0, User0}, 16'h0004);
        check("ch0_evt", {14'h0, Evento0, Evento1}, 16'h0002);
        tick("ch0_after");
        check("ch0_evt_gone", {15'h0, Evento0}, 16'h0000);

        // BTN1 pressed for 3 cycles only: ignored
        btn[1] = 1'b0;
        ticks(3, "btn1_glitch");
        btn[1] = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick("btn1_release");
            pulses += int'(Evento0);
        end
        check("btn1_func0", {13'h0, Func0}, 16'h0000);
        check("btn1_pulses", 16'(pulses), 16'd0);

        // Simultaneous group-1 changes: one pulse
        ch[4] = 1'b1; ch[6] = 1'b1; ch[7] = 1'b1; btn[2] = 1'b0;
        ticks(5, "grp1_wait");
        tick("grp1_edge");
        check("grp1_user1", {13'h0, User1}, 16'h0005);
        check("grp1_func1", {13'h0, Func1}, 16'h0006);
        check("grp1_evt1", {15'h0, Evento1}, 16'h0001);
        tick("grp1_after");
        check("grp1_evt1_gone", {15'h0, Evento1}, 16'h0000);

        // BTN0 bouncing then pressed
        pulses = 0;
        btn[0] = 1'b0; tick("bounce");
        btn[0] = 1'b1; tick("bounce");
        btn[0] = 1'b0; tick("bounce");
        btn[0] = 1'b1; tick("bounce");
        btn[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick("bounce_settle");
            pulses += int'(Evento0);
        end
        check("bounce_not_yet", {15'h0, Func0[1]}, 16'h0000);
        tick("bounce_edge");
        pulses += int'(Evento0);
        check("bounce_func0", {15'h0, Func0[1]}, 16'h0001);
        tick("bounce_after");
        pulses += int'(Evento0);
        check("bounce_pulses", 16'(pulses), 16'd1);

        // Return everything to idle before the reset scenario
        ch = 8'h00; btn = 4'hF;
        ticks(10, "idle");

        // Reset in the middle of a pending CH3 change
        ch[3] = 1'b1;
        ticks(2, "ch3_pending");
        Reset = 1'b1;
        #1;
        check("ch3_reset_async", {4'h0, User0, Func0, User1, Func1}, 16'h0000);
        ticks(2, "ch3_in_reset");
        Reset = 1'b0;
        ticks(5, "ch3_wait");
        check("ch3_not_yet", {13'h0, Func0}, 16'h0000);
        tick("ch3_edge");
        check("ch3_func0", {13'h0, Func0}, 16'h0004);
        check("ch3_evt0", {15'h0, Evento0}, 16'h0001);
        ch[3] = 1'b0;
        ticks(8, "ch3_clear");

        // CH1 and CH5 settle together: both groups pulse
        ch[1] = 1'b1; ch[5] = 1'b1;
        ticks(6, "dual");
        check("dual_evts", {14'h0, Evento0, Evento1}, 16'h0003);
        check("dual_users", {10'h0, User0, User1}, 16'h0012);
        tick("dual_after");

        // Random activity, occasionally with reset
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 49) == 0) begin
                Reset = 1'b1;
                ticks($urandom_range(1, 3), "rand_reset");
                Reset = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) begin
                ch  = 8'($urandom);
                btn = 4'($urandom);
            end else begin
                ch[$urandom_range(0, 7)]  = 1'($urandom);
                btn[$urandom_range(0, 3)] = 1'($urandom);
            end
            ticks($urandom_range(1, 8), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
